// File: rtl/softcore_cpu_debug_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// softcore_cpu_debug_pkg: FSM encoding, control address and jdo field map
// Rev 1.0
// ----------------------------------------------------------------------------
package softcore_cpu_debug_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        J_RD      = 3'd1,
        J_RD_CAP  = 3'd2,
        C_RD      = 3'd3,
        C_RD_DONE = 3'd4
    } mon_state_e;

    localparam logic [8:0] CTRL_ADDR = 9'h100;

    localparam int JDO_ADDR_LSB      = 25;
    localparam int JDO_ADDR_MSB      = 32;
    localparam int JDO_DATA_LSB      = 3;
    localparam int JDO_DATA_MSB      = 34;
    localparam int JDO_RD_AFTER_LOAD = 17;
    localparam int JDO_CLR_STATUS    = 35;

endpackage
`default_nettype wire

// File: rtl/softcore_cpu_debug_mon_ram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// softcore_cpu_debug_mon_ram: single-port RAM, 1-cycle read, byte-lane writes
// Rev 1.0
// ----------------------------------------------------------------------------
module softcore_cpu_debug_mon_ram #(
    parameter int WORDS = 256,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/softcore_cpu_debug_mon_mem.sv
`default_nettype none
// ----------------------------------------------------------------------------
// softcore_cpu_debug_mon_mem: JTAG monitor memory stage arbitrating with CPU
// Rev 1.0
// ----------------------------------------------------------------------------
module softcore_cpu_debug_mon_mem
    import softcore_cpu_debug_pkg::*;
#(
    parameter int RAM_WORDS = 256,
    parameter int JDO_W     = 38
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [JDO_W-1:0] jdo,
    input  logic             take_action_ocimem_a,
    input  logic             take_action_ocimem_b,
    input  logic             take_no_action_ocimem_a,
    input  logic [8:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    input  logic [3:0]       avs_byteenable,
    output logic [31:0]      avs_readdata,
    output logic             avs_waitrequest,
    output logic [31:0]      MonDReg,
    output logic             monitor_ready,
    output logic             monitor_error
);

    localparam int AW = $clog2(RAM_WORDS);

    mon_state_e    state_q, state_d;
    logic [AW-1:0] mon_a_q, mon_a_d;
    logic [31:0]   mon_d_q, mon_d_d;
    logic          ready_q, ready_d;
    logic          error_q, error_d;
    logic          jpend_q, jpend_d;
    logic          jpend_wr_q, jpend_wr_d;
    logic [31:0]   jpend_data_q, jpend_data_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          ram_en;
    logic          ram_we;
    logic [3:0]    ram_be;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    logic          strobe_any;
    logic          is_ram;
    logic          grant;
    logic          unused_jdo;

    assign strobe_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign is_ram     = (avs_address[8] == 1'b0);
    assign unused_jdo = ^{jdo[JDO_W-1:JDO_CLR_STATUS+1], jdo[JDO_DATA_LSB-1:0]};

    softcore_cpu_debug_mon_ram #(
        .WORDS (RAM_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d      = state_q;
        mon_a_d      = mon_a_q;
        mon_d_d      = mon_d_q;
        ready_d      = ready_q;
        error_d      = error_q;
        jpend_d      = jpend_q;
        jpend_wr_d   = jpend_wr_q;
        jpend_data_d = jpend_data_q;
        rdata_d      = rdata_q;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_be       = 4'h0;
        ram_addr     = mon_a_q;
        ram_wdata    = jpend_data_q;
        grant        = 1'b0;

        case (state_q)
            IDLE: begin
                if (jpend_q) begin
                    ram_en = 1'b1;
                    if (jpend_wr_q) begin
                        ram_we  = 1'b1;
                        ram_be  = 4'hF;
                        mon_a_d = mon_a_q + AW'(1);
                        jpend_d = 1'b0;
                    end else begin
                        state_d = J_RD;
                    end
                // A strobe in this cycle is posted and must be served before the CPU
                end else if (!strobe_any && avs_write) begin
                    grant = 1'b1;
                    if (is_ram) begin
                        ram_en    = 1'b1;
                        ram_we    = 1'b1;
                        ram_be    = avs_byteenable;
                        ram_addr  = avs_address[AW-1:0];
                        ram_wdata = avs_writedata;
                    end else if (avs_address == CTRL_ADDR) begin
                        ready_d = ready_q | avs_writedata[0];
                        error_d = error_q | avs_writedata[1];
                    end
                end else if (!strobe_any && avs_read) begin
                    ram_en   = is_ram;
                    ram_addr = avs_address[AW-1:0];
                    state_d  = C_RD;
                end
            end
            J_RD: begin
                mon_d_d = ram_rdata;
                mon_a_d = mon_a_q + AW'(1);
                jpend_d = 1'b0;
                state_d = J_RD_CAP;
            end
            J_RD_CAP: begin
                state_d = IDLE;
            end
            C_RD: begin
                if (is_ram) begin
                    rdata_d = ram_rdata;
                end else if (avs_address == CTRL_ADDR) begin
                    rdata_d = {30'b0, error_q, ready_q};
                end else begin
                    rdata_d = 32'h0;
                end
                state_d = C_RD_DONE;
            end
            C_RD_DONE: begin
                grant   = avs_read;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // New strobes override any completion of the pending slot this cycle
        if (take_action_ocimem_a) begin
            mon_a_d = AW'(jdo[JDO_ADDR_MSB:JDO_ADDR_LSB]);
            if (jdo[JDO_CLR_STATUS]) begin
                ready_d = 1'b0;
                error_d = 1'b0;
            end
            if (jdo[JDO_RD_AFTER_LOAD]) begin
                jpend_d    = 1'b1;
                jpend_wr_d = 1'b0;
            end
        end
        if (take_action_ocimem_b) begin
            jpend_d      = 1'b1;
            jpend_wr_d   = 1'b1;
            jpend_data_d = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
        end
        if (take_no_action_ocimem_a) begin
            jpend_d    = 1'b1;
            jpend_wr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            mon_a_q      <= '0;
            mon_d_q      <= '0;
            ready_q      <= 1'b0;
            error_q      <= 1'b0;
            jpend_q      <= 1'b0;
            jpend_wr_q   <= 1'b0;
            jpend_data_q <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            mon_a_q      <= mon_a_d;
            mon_d_q      <= mon_d_d;
            ready_q      <= ready_d;
            error_q      <= error_d;
            jpend_q      <= jpend_d;
            jpend_wr_q   <= jpend_wr_d;
            jpend_data_q <= jpend_data_d;
            rdata_q      <= rdata_d;
        end
    end

    assign avs_waitrequest = (avs_read | avs_write) & ~grant;
    assign avs_readdata    = rdata_q;
    assign MonDReg         = mon_d_q;
    assign monitor_ready   = ready_q;
    assign monitor_error   = error_q;

endmodule
`default_nettype wire

// File: tb/tb_softcore_cpu_debug_mon_mem.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_softcore_cpu_debug_mon_mem: directed + random checks against a RAM model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_softcore_cpu_debug_mon_mem;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [8:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    always #5 clk = ~clk;

    softcore_cpu_debug_mon_mem #(
        .RAM_WORDS (256),
        .JDO_W     (38)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    // Reference model state
    logic [31:0] ram_m [256];
    logic [7:0]  mona_m;
    logic [31:0] mond_m;
    logic        rdy_m;
    logic        err_m;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [37:0] rand38();
        return {6'($urandom()), $urandom()};
    endfunction

    function automatic logic [31:0] cpu_expect(input logic [8:0] a);
        if (a < 9'h100)       return ram_m[a[7:0]];
        else if (a == 9'h100) return {30'b0, err_m, rdy_m};
        else                  return 32'h0;
    endfunction

    task automatic check_status(input string tag);
        check_eq({tag, "_ready"}, 32'(monitor_ready), 32'(rdy_m));
        check_eq({tag, "_error"}, 32'(monitor_error), 32'(err_m));
    endtask

    // kind: 0 = ocimem_a, 1 = ocimem_b, 2 = no_action_a; leaves 8 quiet cycles after
    task automatic jtag_strobe(input int kind, input logic [37:0] j);
        jdo                     = j;
        take_action_ocimem_a    = (kind == 0);
        take_action_ocimem_b    = (kind == 1);
        take_no_action_ocimem_a = (kind == 2);
        @(posedge clk); #1;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        jdo                     = rand38();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic jtag_load(input logic [7:0] a, input logic clr, input logic rd);
        logic [37:0] j;
        j        = rand38();
        j[32:25] = a;
        j[35]    = clr;
        j[17]    = rd;
        jtag_strobe(0, j);
        mona_m = a;
        if (clr) begin
            rdy_m = 1'b0;
            err_m = 1'b0;
        end
        if (rd) begin
            mond_m = ram_m[mona_m];
            mona_m = mona_m + 8'd1;
        end
        check_eq("jload_mond", MonDReg, mond_m);
        check_status("jload");
    endtask

    task automatic jtag_write(input logic [31:0] d);
        logic [37:0] j;
        j       = rand38();
        j[34:3] = d;
        jtag_strobe(1, j);
        ram_m[mona_m] = d;
        mona_m        = mona_m + 8'd1;
        check_eq("jwrite_mond", MonDReg, mond_m);
    endtask

    task automatic jtag_read();
        jtag_strobe(2, rand38());
        mond_m = ram_m[mona_m];
        mona_m = mona_m + 8'd1;
        check_eq("jread_mond", MonDReg, mond_m);
    endtask

    task automatic cpu_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be);
        int waits;
        avs_address    = a;
        avs_writedata  = d;
        avs_byteenable = be;
        avs_write      = 1'b1;
        waits          = 0;
        @(negedge clk);
        while (avs_waitrequest && waits < 40) begin
            waits++;
            @(negedge clk);
        end
        check_eq("cwrite_timeout", 32'(avs_waitrequest), 32'h0);
        @(posedge clk); #1;
        avs_write = 1'b0;
        if (a < 9'h100) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) ram_m[a[7:0]][8*i +: 8] = d[8*i +: 8];
            end
        end else if (a == 9'h100) begin
            rdy_m = rdy_m | d[0];
            err_m = err_m | d[1];
        end
        check_eq("cwrite_waits", waits, 0);
    endtask

    task automatic cpu_read(input logic [8:0] a, output logic [31:0] d);
        int waits;
        avs_address = a;
        avs_read    = 1'b1;
        waits       = 0;
        @(negedge clk);
        while (avs_waitrequest && waits < 40) begin
            waits++;
            @(negedge clk);
        end
        check_eq("cread_timeout", 32'(avs_waitrequest), 32'h0);
        d = avs_readdata;
        @(posedge clk); #1;
        avs_read = 1'b0;
        check_eq("cread_data", d, cpu_expect(a));
        check_eq("cread_waits", waits, 2);
    endtask

    initial begin
        logic [31:0] d;
        int          waits;
        int          op;

        reset_n                 = 1'b0;
        jdo                     = '0;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        avs_address             = '0;
        avs_read                = 1'b0;
        avs_write               = 1'b0;
        avs_writedata           = '0;
        avs_byteenable          = '0;
        mona_m = 8'h0;
        mond_m = 32'h0;
        rdy_m  = 1'b0;
        err_m  = 1'b0;

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_mond", MonDReg, 32'h0);
        check_eq("rst_readdata", avs_readdata, 32'h0);
        check_eq("rst_wait", 32'(avs_waitrequest), 32'h0);
        check_status("rst");

        // Give every RAM word a known value
        for (int a = 0; a < 256; a++) cpu_write(9'(a), $urandom(), 4'hF);

        // JTAG write then read-back
        jtag_load(8'h10, 1'b0, 1'b0);
        jtag_write(32'hDEADBEEF);
        jtag_load(8'h10, 1'b0, 1'b1);
        check_eq("wrb_value", MonDReg, 32'hDEADBEEF);
        jtag_read();   // lands at 0x11 only if the address advanced after the read

        // Auto-increment wrap
        jtag_load(8'hFF, 1'b0, 1'b0);
        jtag_write(32'h1);
        jtag_write(32'h2);
        jtag_read();   // address should now be 0x01
        jtag_load(8'hFF, 1'b0, 1'b1);
        check_eq("wrap_ff", MonDReg, 32'h1);
        jtag_read();
        check_eq("wrap_00", MonDReg, 32'h2);

        // CPU byte-lane write
        jtag_load(8'h20, 1'b0, 1'b0);
        jtag_write(32'h11223344);
        cpu_write(9'h020, 32'hAABBCCDD, 4'b0101);
        cpu_read(9'h020, d);
        check_eq("lane_value", d, 32'h11BB33DD);

        // Status handshake
        cpu_write(9'h100, 32'h3, 4'h0);
        check_eq("stat_set", {30'b0, monitor_error, monitor_ready}, 32'h3);
        cpu_read(9'h100, d);
        jtag_load(8'h00, 1'b1, 1'b0);
        check_eq("stat_clr", {30'b0, monitor_error, monitor_ready}, 32'h0);
        cpu_write(9'h100, 32'h1, 4'hF);
        check_status("stat_rdy_only");
        cpu_write(9'h100, 32'h0, 4'hF);
        check_status("stat_zero");

        // Unmapped space
        cpu_write(9'h155, 32'h12345678, 4'hF);
        cpu_read(9'h155, d);
        cpu_read(9'h055, d);
        check_status("unmapped");

        // Contention: JTAG read and CPU read in the same cycle
        cpu_write(9'h040, 32'hCAFEF00D, 4'hF);
        cpu_write(9'h041, 32'h0BADC0DE, 4'hF);
        jtag_load(8'h40, 1'b0, 1'b0);
        jdo                     = rand38();
        take_no_action_ocimem_a = 1'b1;
        avs_address             = 9'h041;
        avs_read                = 1'b1;
        @(negedge clk);
        check_eq("cont_wait0", 32'(avs_waitrequest), 32'h1);
        waits = 1;
        @(posedge clk); #1;
        take_no_action_ocimem_a = 1'b0;
        @(negedge clk);
        while (avs_waitrequest && waits < 40) begin
            waits++;
            @(negedge clk);
        end
        mond_m = ram_m[mona_m];
        mona_m = mona_m + 8'd1;
        check_eq("cont_timeout", 32'(avs_waitrequest), 32'h0);
        check_eq("cont_mond_first", MonDReg, 32'hCAFEF00D);
        check_eq("cont_rdata", avs_readdata, 32'h0BADC0DE);
        // strobe cycle + J service (3) + CPU read (2)
        check_eq("cont_waits", waits, 6);
        @(posedge clk); #1;
        avs_read = 1'b0;

        // Reset while the JTAG read sits in J_RD
        jdo                     = rand38();
        take_no_action_ocimem_a = 1'b1;
        @(posedge clk); #1;
        take_no_action_ocimem_a = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #2;
        mona_m = 8'h0;
        mond_m = 32'h0;
        rdy_m  = 1'b0;
        err_m  = 1'b0;
        check_eq("midrst_mond", MonDReg, 32'h0);
        check_eq("midrst_rdata", avs_readdata, 32'h0);
        check_status("midrst");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_eq("postrst_mond", MonDReg, 32'h0);
        check_eq("postrst_wait", 32'(avs_waitrequest), 32'h0);
        jtag_read();   // address register must be back at zero

        // Randomized mix
        for (int it = 0; it < 300; it++) begin
            op = $urandom_range(0, 5);
            case (op)
                0: jtag_load(8'($urandom()), 1'($urandom_range(0, 3) == 0), 1'($urandom()));
                1: jtag_write($urandom());
                2: jtag_read();
                3: begin
                    logic [8:0] a;
                    a = ($urandom_range(0, 7) == 0) ? 9'h100 : 9'($urandom());
                    cpu_write(a, $urandom(), 4'($urandom()));
                end
                default: begin
                    logic [8:0] a;
                    a = ($urandom_range(0, 7) == 0) ? 9'h100 : 9'($urandom());
                    cpu_read(a, d);
                end
            endcase
        end
        check_status("final");
        check_eq("final_mond", MonDReg, mond_m);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
